wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Round-robin Wishbone bus arbiter that lets several bus masters (the CPU, plus DMA-style masters such as a VGA frame fetcher) share the single master port of `WB_intercon`. It sits between the masters and the interconnect. It grants the bus to one master per transaction and holds the grant until that transaction ends. It routes strobe, write-enable, address and data to the interconnect, and returns ACK and read data to the owner. An optional watchdog terminates transactions that no slave acknowledges.

## Interface
- `NUM_MASTERS`, 2: number of requesting masters, 2..8.
- `DATA_WIDTH`, 32: data bus width.
- `ADDR_WIDTH`, 32: address bus width.
- `TIMEOUT_CYCLES`, 255: number of BUSY cycles without ACK before the bus error fires. Range 2..255, 8-bit counter.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `m_STB`  in  NUM_MASTERS  per-master request/strobe.
- `m_WE`  in  NUM_MASTERS  per-master write enable.
- `m_ADDR`  in  NUM_MASTERS*ADDR_WIDTH  packed addresses; master i is at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- `m_DAT_I`  in  NUM_MASTERS*DATA_WIDTH  packed write data, same packing as `m_ADDR`.
- `m_DAT_O`  out  DATA_WIDTH  read data, broadcast to all masters; valid only with that master's ACK.
- `m_ACK`  out  NUM_MASTERS  per-master acknowledge.
- `m_ERR`  out  NUM_MASTERS  per-master timeout error pulse.
- `s_STB`  out  1  strobe to the interconnect `master_STB`.
- `s_WE`  out  1  write enable to the interconnect.
- `s_ADDR`  out  ADDR_WIDTH  address to the interconnect.
- `s_DAT_O`  out  DATA_WIDTH  write data to the interconnect `master_DAT_I`.
- `s_DAT_I`  in  DATA_WIDTH  read data from the interconnect `master_DAT_O`.
- `s_ACK`  in  1  acknowledge from the interconnect.
- `grant`  out  NUM_MASTERS  one-hot current owner; all zeros when not BUSY.
- `busy`  out  1  high in BUSY state.

## Operation
States:
- **IDLE**
  - `s_STB`=0 and `grant`=0.
  - If any `m_STB` is high, the arbiter selects the first requester found by scanning upward from `rr_ptr`, wrapping modulo NUM_MASTERS.
  - The selected index is registered as the owner and the state moves to BUSY.
  - If no master is requesting, the state stays IDLE.
- **BUSY**
  - `s_STB`, `s_WE`, `s_ADDR` and `s_DAT_O` are combinationally muxed from the owner.
  - `m_ACK[owner]` = `s_ACK`. `m_DAT_O` = `s_DAT_I`.
  - Every other master sees ACK=0 and ERR=0.
  - On an edge with `s_ACK`=1: go to IDLE and set `rr_ptr` = (owner+1) mod NUM_MASTERS.
  - On an edge with `m_STB[owner]`=0 (master abandons the transaction): go to IDLE with the same `rr_ptr` update, no ACK is forwarded afterwards.
  - Otherwise the timeout counter increments.
- **ERR** (present only with the watchdog compiled in)
  - Lasts exactly one cycle.
  - `s_STB`=0, `m_ERR[owner]`=1.
  - Then go to IDLE with the same `rr_ptr` update.

Rules:
- The grant is locked for the whole transaction. A requester that raises `m_STB` mid-transaction waits.
- Masters hold STB/WE/ADDR/DAT stable until they see ACK or ERR, then drop STB.
- `s_ACK` arriving in IDLE or ERR is ignored and never forwarded. This covers a late ACK after a timeout.
- Simultaneous requests are resolved strictly by `rr_ptr` order. The last owner has the lowest priority next time.
- Reset values:
  - state IDLE, `rr_ptr`=0, owner=0, counter=0.
  - All outputs 0: `s_STB`, `s_WE`, `s_ADDR`, `s_DAT_O`, `m_ACK`, `m_ERR`, `m_DAT_O`, `grant`, `busy`.
- Reset asserted mid-transaction: the state returns to IDLE at that edge and `s_STB` is low in the following cycle. A pending ACK is dropped.

## Timing
- Arbitration latency is 1 cycle. A request seen in IDLE at edge N produces `s_STB`=1 in cycle N+1.
- ACK path from `s_ACK` to `m_ACK` is combinational, 0 cycles. `m_DAT_O` is likewise combinational from `s_DAT_I`.
- Minimum transaction is 2 cycles: 1 IDLE cycle plus 1 BUSY cycle with an immediate ACK.
- Back-to-back transactions always have one IDLE (arbitration) cycle between them.
- The timeout counter resets to 0 on entry to BUSY and increments once per BUSY cycle without ACK. When counter == TIMEOUT_CYCLES-1 and no ACK is present, the next state is ERR.
- An ACK in the same cycle as the timeout threshold wins: it is a normal completion and no ERR is raised.

## Configuration
- `WB_ARB_TIMEOUT_EN` defined: the watchdog counter and ERR state are built, and `m_ERR` behaves as above.
- `WB_ARB_TIMEOUT_EN` undefined:
  - No counter and no ERR state; BUSY waits indefinitely for ACK or abandon.
  - `m_ERR` is tied to 0 and `TIMEOUT_CYCLES` is ignored.
  - Port list is unchanged.

## Test plan
- **Single read:** master 0 reads 0x0000_0010; slave ACKs 2 cycles after `s_STB` with data 0xDEAD_BEEF.
  - `s_ADDR`=0x10 and `s_WE`=0 from the cycle after the request.
  - `m_ACK[0]` pulses 1 cycle with `m_DAT_O`=0xDEAD_BEEF. `grant` returns to 0.
- **Simultaneous requests:** from reset, masters 0 and 1 raise STB together; slave ACKs immediately.
  - Master 0 is served first, then master 1 after 1 IDLE cycle.
  - `m_ACK[1]` is never high during master 0's transaction.
- **Fairness:** master 0 requests continuously while master 1 requests continuously.
  - Grants alternate 0,1,0,1 and neither master gets 2 consecutive grants.
- **Timeout** (macro on, TIMEOUT_CYCLES=4): master 1 writes 0xFFFF_0000 and the slave never ACKs.
  - After 4 BUSY cycles, `m_ERR[1]` pulses for 1 cycle with `s_STB`=0.
  - A late `s_ACK` one cycle later is not forwarded.
- **Abandon:** master 0 drops STB after 1 BUSY cycle without ACK.
  - Arbiter returns to IDLE and the next requester (master 1) is granted.
- **Reset mid-transaction:** assert reset while BUSY.
  - `s_STB`, `grant` and `busy` are 0 in the next cycle.
  - After reset is released, master 0 has first priority.

Source files
------------

// File: rtl/wb_arbiter.sv
// Round-robin Wishbone arbiter: one bus owner per transaction, grant locked until ACK/abandon.
// Optional watchdog (ERR state + counter) is built only when WB_ARB_TIMEOUT_EN is defined.
module wb_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_MASTERS-1:0]           m_STB,
  input  logic [NUM_MASTERS-1:0]           m_WE,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_ADDR,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_DAT_I,
  output logic [DATA_WIDTH-1:0]            m_DAT_O,
  output logic [NUM_MASTERS-1:0]           m_ACK,
  output logic [NUM_MASTERS-1:0]           m_ERR,
  output logic                             s_STB,
  output logic                             s_WE,
  output logic [ADDR_WIDTH-1:0]            s_ADDR,
  output logic [DATA_WIDTH-1:0]            s_DAT_O,
  input  logic [DATA_WIDTH-1:0]            s_DAT_I,
  input  logic                             s_ACK,
  output logic [NUM_MASTERS-1:0]           grant,
  output logic                             busy
);

  localparam int          OW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int unsigned NM = NUM_MASTERS;

  if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255)
  begin : g_param_range
    $error("wb_arbiter: parameter out of range");
  end

`ifdef WB_ARB_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE, BUSY, ERR} state_t;
`else
  typedef enum logic {IDLE, BUSY} state_t;
`endif

  state_t        state, state_next;
  logic [OW-1:0] owner, rr_ptr, pick, owner_inc;
  logic          pick_valid;
  logic          release_bus;

`ifdef WB_ARB_TIMEOUT_EN
  logic [7:0] cnt;
  logic       timeout_hit;
  assign timeout_hit = (cnt == 8'(TIMEOUT_CYCLES - 1));
`endif

  // First requester scanning upward from rr_ptr, wrapping around.
  always_comb begin
    int unsigned idx;
    idx        = 0;
    pick       = '0;
    pick_valid = 1'b0;
    for (int unsigned i = 0; i < NM; i++) begin
      idx = (32'(rr_ptr) + i) % NM;
      if (!pick_valid && m_STB[OW'(idx)]) begin
        pick_valid = 1'b1;
        pick       = OW'(idx);
      end
    end
  end

  assign owner_inc   = (owner == OW'(NM - 1)) ? '0 : owner + 1'b1;
  assign release_bus = (state != IDLE) && (state_next == IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      owner  <= '0;
      rr_ptr <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && pick_valid) owner <= pick;
      if (release_bus) rr_ptr <= owner_inc;
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset || state != BUSY) cnt <= '0;
    else                        cnt <= cnt + 8'd1;
  end
`endif

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (pick_valid) state_next = BUSY;
      BUSY: begin
        if (s_ACK || !m_STB[owner]) state_next = IDLE;
`ifdef WB_ARB_TIMEOUT_EN
        else if (timeout_hit)       state_next = ERR;
`endif
      end
`ifdef WB_ARB_TIMEOUT_EN
      ERR:  state_next = IDLE;
`endif
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    s_STB   = 1'b0;
    s_WE    = 1'b0;
    s_ADDR  = '0;
    s_DAT_O = '0;
    m_DAT_O = '0;
    m_ACK   = '0;
    m_ERR   = '0;
    grant   = '0;
    busy    = 1'b0;
    if (state == BUSY) begin
      s_STB        = m_STB[owner];
      s_WE         = m_WE[owner];
      s_ADDR       = m_ADDR[int'(owner)*ADDR_WIDTH +: ADDR_WIDTH];
      s_DAT_O      = m_DAT_I[int'(owner)*DATA_WIDTH +: DATA_WIDTH];
      m_DAT_O      = s_DAT_I;
      m_ACK[owner] = s_ACK;
      grant[owner] = 1'b1;
      busy         = 1'b1;
    end
`ifdef WB_ARB_TIMEOUT_EN
    if (state == ERR) m_ERR[owner] = 1'b1;
`endif
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus randomized masters/slave
// compared every cycle against a transaction-level model of the arbitration rules.
module tb_wb_arbiter;
  localparam int NM = 2;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 4;
`ifdef WB_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic [NM-1:0]     m_STB, m_WE, m_ACK, m_ERR, grant;
  logic [NM*AW-1:0]  m_ADDR;
  logic [NM*DW-1:0]  m_DAT_I;
  logic [DW-1:0]     m_DAT_O, s_DAT_O, s_DAT_I;
  logic [AW-1:0]     s_ADDR;
  logic              s_STB, s_WE, s_ACK, busy;

  wb_arbiter #(.NUM_MASTERS(NM), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .m_STB(m_STB), .m_WE(m_WE), .m_ADDR(m_ADDR), .m_DAT_I(m_DAT_I),
    .m_DAT_O(m_DAT_O), .m_ACK(m_ACK), .m_ERR(m_ERR), .s_STB(s_STB), .s_WE(s_WE),
    .s_ADDR(s_ADDR), .s_DAT_O(s_DAT_O), .s_DAT_I(s_DAT_I), .s_ACK(s_ACK),
    .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: who owns the bus, whose turn is next, how long the owner has waited.
  bit md_busy = 0, md_err = 0, cmp_en = 0;
  int md_owner = 0, md_ptr = 0, md_cycles = 0;

  always @(posedge clk) begin
    int c;
    c = 0;
    if (reset) begin
      md_busy = 0; md_err = 0; md_owner = 0; md_ptr = 0; md_cycles = 0;
    end else if (md_err) begin
      md_err = 0;
      md_ptr = (md_owner + 1) % NM;
    end else if (md_busy) begin
      if (s_ACK || !m_STB[md_owner]) begin
        md_busy = 0;
        md_ptr  = (md_owner + 1) % NM;
      end else begin
        md_cycles++;
        if (TO_EN && md_cycles == TO) begin
          md_busy = 0;
          md_err  = 1;
        end
      end
    end else begin
      for (int k = 0; k < NM; k++) begin
        c = (md_ptr + k) % NM;
        if (m_STB[c]) begin
          md_busy = 1; md_owner = c; md_cycles = 0;
          break;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [NM-1:0] eg, ea, ee;
    logic          es, ew;
    logic [AW-1:0] ead;
    logic [DW-1:0] edo, edi;
    eg = '0; ea = '0; ee = '0; es = 0; ew = 0; ead = '0; edo = '0; edi = '0;
    if (cmp_en) begin
      if (md_busy) begin
        eg[md_owner] = 1'b1;
        ea[md_owner] = s_ACK;
        es  = m_STB[md_owner];
        ew  = m_WE[md_owner];
        ead = m_ADDR[md_owner*AW +: AW];
        edo = m_DAT_I[md_owner*DW +: DW];
        edi = s_DAT_I;
      end
      if (md_err) ee[md_owner] = 1'b1;
      chk("grant", grant, eg);
      chk("busy", busy, md_busy);
      chk("s_STB", s_STB, es);
      chk("s_WE", s_WE, ew);
      chk("s_ADDR", s_ADDR, ead);
      chk("s_DAT_O", s_DAT_O, edo);
      chk("m_ACK", m_ACK, ea);
      chk("m_DAT_O", m_DAT_O, edi);
      chk("m_ERR", m_ERR, ee);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; m_STB = '0; m_WE = '0; s_ACK = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    logic [NM-1:0] seq[$];
    logic [NM-1:0] ack_seen, err_seen;
    reset = 1'b1; m_STB = '0; m_WE = '0; m_ADDR = '0; m_DAT_I = '0;
    s_ACK = 1'b0; s_DAT_I = '0;
    tick(); tick();
    cmp_en = 1;
    #1;
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_s_STB", s_STB, 0);
    chk("rst_m_DAT_O", m_DAT_O, 0);
    reset = 1'b0;

    // Single read by master 0, slave acks two cycles after strobe
    m_ADDR[0 +: AW] = 32'h0000_0010; m_WE = 2'b00; m_STB = 2'b01;
    tick(); #1;
    chk("sr_s_STB", s_STB, 1);
    chk("sr_s_ADDR", s_ADDR, 32'h10);
    chk("sr_s_WE", s_WE, 0);
    chk("sr_grant", grant, 2'b01);
    tick(); tick();
    s_ACK = 1'b1; s_DAT_I = 32'hDEAD_BEEF; #1;
    chk("sr_m_ACK", m_ACK, 2'b01);
    chk("sr_m_DAT_O", m_DAT_O, 32'hDEAD_BEEF);
    tick();
    m_STB = 2'b00; s_ACK = 1'b0; #1;
    chk("sr_ack_pulse", m_ACK, 0);
    chk("sr_grant_rel", grant, 0);

    // Simultaneous requests from reset
    do_reset();
    m_ADDR[0 +: AW] = 32'h100; m_ADDR[AW +: AW] = 32'h200; m_STB = 2'b11;
    tick();
    s_ACK = 1'b1; #1;
    chk("sim_grant0", grant, 2'b01);
    chk("sim_ack0", m_ACK, 2'b01);
    tick();
    m_STB = 2'b10; s_ACK = 1'b0; #1;
    chk("sim_idle", grant, 0);
    tick();
    s_ACK = 1'b1; #1;
    chk("sim_grant1", grant, 2'b10);
    chk("sim_ack1", m_ACK, 2'b10);
    tick();
    m_STB = 2'b00; s_ACK = 1'b0;

    // Fairness: both request continuously, slave acks immediately
    m_STB = 2'b11; s_ACK = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick(); #1;
      if (grant != 0) seq.push_back(grant);
    end
    chk("fair_count", seq.size(), 4);
    foreach (seq[k]) chk("fair_order", seq[k], (k % 2 == 0) ? 2'b01 : 2'b10);
    m_STB = 2'b00; s_ACK = 1'b0;

    // Abandon: master 0 drops strobe after one BUSY cycle
    do_reset();
    m_STB = 2'b01;
    tick(); #1;
    chk("ab_grant", grant, 2'b01);
    m_STB = 2'b10; #1;
    chk("ab_s_STB", s_STB, 0);
    tick(); #1;
    chk("ab_idle", busy, 0);
    tick(); #1;
    chk("ab_next", grant, 2'b10);
    s_ACK = 1'b1;
    tick();
    m_STB = 2'b00; s_ACK = 1'b0;

`ifdef WB_ARB_TIMEOUT_EN
    // Timeout: master 1 writes, slave never acks
    do_reset();
    m_ADDR[AW +: AW] = 32'h20; m_DAT_I[DW +: DW] = 32'hFFFF_0000; m_WE = 2'b10; m_STB = 2'b10;
    tick(); #1;
    chk("to_s_DAT_O", s_DAT_O, 32'hFFFF_0000);
    chk("to_s_WE", s_WE, 1);
    tick(); tick(); tick(); #1;
    chk("to_still_busy", busy, 1);
    tick(); #1;
    chk("to_m_ERR", m_ERR, 2'b10);
    chk("to_s_STB", s_STB, 0);
    chk("to_busy", busy, 0);
    m_STB = 2'b00; m_WE = 2'b00;
    tick();
    s_ACK = 1'b1; #1;
    chk("to_late_ack", m_ACK, 0);
    chk("to_err_pulse", m_ERR, 0);
    tick();
    s_ACK = 1'b0;
`endif

    // Reset asserted mid-transaction
    do_reset();
    m_STB = 2'b01;
    tick(); #1;
    chk("rm_busy", busy, 1);
    reset = 1'b1; s_ACK = 1'b1;
    tick(); #1;
    chk("rm_s_STB", s_STB, 0);
    chk("rm_grant", grant, 0);
    chk("rm_busy0", busy, 0);
    reset = 1'b0; s_ACK = 1'b0; m_STB = 2'b11;
    tick(); #1;
    chk("rm_prio", grant, 2'b01);
    s_ACK = 1'b1;
    tick();
    m_STB = 2'b00; s_ACK = 1'b0;

    // Randomized masters and slave
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      #1;
      ack_seen = m_ACK;
      err_seen = m_ERR;
      tick();
      for (int i = 0; i < NM; i++) begin
        if (m_STB[i]) begin
          if (ack_seen[i] || err_seen[i]) m_STB[i] = 1'b0;
          else if ($urandom_range(0, 29) == 0) m_STB[i] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          m_STB[i] = 1'b1;
          m_WE[i]  = 1'($urandom);
          m_ADDR[i*AW +: AW]  = $urandom;
          m_DAT_I[i*DW +: DW] = $urandom;
        end
      end
      s_ACK   = ($urandom_range(0, 3) == 0);
      s_DAT_I = $urandom;
      reset   = ($urandom_range(0, 199) == 0);
    end
    reset = 1'b0; m_STB = '0; s_ACK = 1'b0;
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
